// File: rtl/vram_pkg.sv
// vram_pkg: shared widths and default VGA timing for the VRAM window reader.
// Contents: ZBT address width, pixel width, read-word width, default
// H_TOTAL/V_TOTAL (1344 x 806) and the address type.
package vram_pkg;
    localparam int ADDR_W      = 19;
    localparam int PIX_W       = 30;
    localparam int DATA_W      = 36;
    localparam int H_TOTAL_DEF = 1344;
    localparam int V_TOTAL_DEF = 806;
    typedef logic [ADDR_W-1:0] addr_t;
endpackage

// File: rtl/vram_fetch_pipe.sv
// vram_fetch_pipe: RD_LAT-deep valid delay line that lines the window flag up
// with the ZBT read word, then registers the displayed pixel.
// Ports:
//   clk, reset       pixel clock, async active-high reset
//   valid            forecast point lies inside the window (same edge as vram_addr)
//   data             RGB 10:10:10 part of the returned read word
//   pixel            registered pixel: data when aligned valid is high, else BG_PIXEL
//   in_window        registered aligned valid
module vram_fetch_pipe
    import vram_pkg::*;
#(
    parameter int               RD_LAT   = 2,
    parameter logic [PIX_W-1:0] BG_PIXEL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid,
    input  logic [PIX_W-1:0] data,
    output logic [PIX_W-1:0] pixel,
    output logic             in_window
);
    logic [RD_LAT-1:0] vpipe;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vpipe     <= '0;
            pixel     <= '0;
            in_window <= 1'b0;
        end else begin
            vpipe     <= (vpipe << 1) | RD_LAT'(valid);
            in_window <= vpipe[RD_LAT-1];
            pixel     <= vpipe[RD_LAT-1] ? data : BG_PIXEL;
        end
    end
endmodule

// File: rtl/vram_window_reader.sv
// vram_window_reader: fetches an IMG_W x IMG_H image from ZBT VRAM and places it
// on screen at (XOFFSET, YOFFSET), driving BG_PIXEL elsewhere.
// Ports:
//   clk, reset       pixel clock, async active-high reset
//   hcount, vcount   current screen column / row
//   vram_addr        registered ZBT word address (holds outside the window)
//   vram_read_data   ZBT read word, RD_LAT cycles after vram_addr; [29:0] is RGB
//   vr_pixel         registered display pixel for the sampled (hcount, vcount)
//   in_window        registered, high when vr_pixel carries image data
//   frame_start      one-cycle pulse when image pixel (0,0) is addressed
// Build option: define VRAM_SCALE2X_EN to show every image pixel as a 2x2 block.
module vram_window_reader
    import vram_pkg::*;
#(
    parameter int               XOFFSET  = 0,
    parameter int               YOFFSET  = 0,
    parameter int               IMG_W    = 640,
    parameter int               IMG_H    = 480,
    parameter int               H_TOTAL  = H_TOTAL_DEF,
    parameter int               V_TOTAL  = V_TOTAL_DEF,
    parameter int               RD_LAT   = 2,
    parameter logic [PIX_W-1:0] BG_PIXEL = 30'd0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [10:0]       hcount,
    input  logic [9:0]        vcount,
    output logic [ADDR_W-1:0] vram_addr,
    input  logic [DATA_W-1:0] vram_read_data,
    output logic [PIX_W-1:0]  vr_pixel,
    output logic              in_window,
    output logic              frame_start
);
`ifdef VRAM_SCALE2X_EN
    localparam int SCALE = 2;
`else
    localparam int SCALE = 1;
`endif
    localparam int WIN_W = IMG_W * SCALE;
    localparam int WIN_H = IMG_H * SCALE;

    generate
        if (longint'(IMG_W) * longint'(IMG_H) > (longint'(1) << ADDR_W) || RD_LAT < 1 || RD_LAT > 4) begin : g_bad_cfg
            $error("vram_window_reader: image larger than VRAM or RD_LAT outside 1..4");
        end
    endgenerate

    logic [11:0] h_sum;
    logic        h_wrap;
    logic [10:0] hf;
    logic [9:0]  vf;
    logic [9:0]  vf_q;
    int          h_rel;
    int          v_rel;
    int          col;
    logic        col_in;
    logic        row_in;
    logic        row_chg;
    logic        row_adv;
    logic        synced;
    logic        synced_nxt;
    logic        win;
    addr_t       row_base;
    addr_t       rb_nxt;
    logic        unused_data;

    assign unused_data = ^vram_read_data[DATA_W-1:PIX_W];

    // Forecast the point whose data will return when the screen reaches it.
    // Relative coordinates are kept in 32-bit signed arithmetic so points left
    // of or above the offset stay negative instead of wrapping into the window.
    // row_base is only trusted after it has been zeroed at row YOFFSET, so a
    // mid-frame reset release shows background rather than misplaced rows.
    always_comb begin
        h_sum      = 12'(hcount) + 12'(RD_LAT);
        h_wrap     = h_sum >= 12'(H_TOTAL);
        hf         = h_wrap ? 11'(h_sum - 12'(H_TOTAL)) : h_sum[10:0];
        vf         = !h_wrap ? vcount : (vcount >= 10'(V_TOTAL - 1) ? '0 : vcount + 10'd1);
        h_rel      = int'(hf) - XOFFSET;
        v_rel      = int'(vf) - YOFFSET;
        col_in     = h_rel >= 0 && h_rel < WIN_W;
        row_in     = v_rel >= 0 && v_rel < WIN_H;
`ifdef VRAM_SCALE2X_EN
        col        = h_rel >>> 1;
        row_adv    = v_rel > 0 && v_rel < WIN_H && !v_rel[0];
`else
        col        = h_rel;
        row_adv    = v_rel > 0 && v_rel < WIN_H;
`endif
        row_chg    = vf != vf_q;
        rb_nxt     = !row_chg ? row_base : v_rel == 0 ? '0 : row_adv ? row_base + addr_t'(IMG_W) : row_base;
        synced_nxt = synced || (row_chg && v_rel == 0);
        win        = synced_nxt && col_in && row_in;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vf_q        <= '0;
            row_base    <= '0;
            synced      <= 1'b0;
            vram_addr   <= '0;
            frame_start <= 1'b0;
        end else begin
            vf_q        <= vf;
            row_base    <= rb_nxt;
            synced      <= synced_nxt;
            if (win)
                vram_addr <= rb_nxt + addr_t'(col);
            frame_start <= win && h_rel == 0 && v_rel == 0;
        end
    end

    vram_fetch_pipe #(
        .RD_LAT  (RD_LAT),
        .BG_PIXEL(BG_PIXEL)
    ) u_pipe (
        .clk      (clk),
        .reset    (reset),
        .valid    (win),
        .data     (vram_read_data[PIX_W-1:0]),
        .pixel    (vr_pixel),
        .in_window(in_window)
    );
endmodule

// File: doc/vram_window_reader.md
VRAM_WINDOW_READER -- requirements
Module: vram_window_reader

Interface
REQ-001 Parameter XOFFSET, default 0: screen column of the image's left edge.
REQ-002 Parameter YOFFSET, default 0: screen row of the image's top edge.
REQ-003 Parameter IMG_W, default 640: image width in VRAM words.
REQ-004 Parameter IMG_H, default 480: image height in VRAM lines.
REQ-005 Parameter H_TOTAL, default 1344: hcount period, including blanking.
REQ-006 Parameter V_TOTAL, default 806: vcount period, including blanking.
REQ-007 Parameter RD_LAT, default 2: number of clk cycles from vram_addr registered to matching vram_read_data; legal range 1..4.
REQ-008 Parameter BG_PIXEL, default 30'd0: pixel value driven outside the window.
REQ-009 clk  input  1: pixel clock, rising edge.
REQ-010 reset  input  1: asynchronous, active-high reset.
REQ-011 hcount  input  11: current screen column, 0..H_TOTAL-1.
REQ-012 vcount  input  10: current screen row, 0..V_TOTAL-1.
REQ-013 vram_addr  output  19: registered ZBT word address.
REQ-014 vram_read_data  input  36: ZBT read word; bits [29:0] are RGB 10:10:10.
REQ-015 vr_pixel  output  30: registered display pixel.
REQ-016 in_window  output  1: registered; high when vr_pixel carries image data.
REQ-017 frame_start  output  1: one-cycle pulse when the image pixel at (0,0) is fetched.

Function
REQ-018 The clock edge that samples (hcount=h, vcount=v) SHALL make vr_pixel equal image pixel (h-XOFFSET, v-YOFFSET) when that point lies inside the window, and BG_PIXEL otherwise.
REQ-019 The block SHALL meet REQ-018 by forecasting hcount by RD_LAT columns, wrapping at H_TOTAL; a column wrap SHALL advance the forecast row, which wraps at V_TOTAL.
REQ-020 The in-window flag for the forecast point SHALL be delayed through an RD_LAT-deep shift register, so the pixel/background select aligns with the returned data.
REQ-021 Coordinates left of or above the offset SHALL be treated as outside the window; 11-bit and 10-bit subtraction wrap-around SHALL NOT alias into the window.
REQ-022 Address generation SHALL use an incremental row-base register, not a multiplier: row_base resets to 0 at forecast row YOFFSET and adds IMG_W at each forecast-row change inside the window.
REQ-023 Inside the window, vram_addr SHALL equal row_base + column.
REQ-024 Outside the window, vram_addr SHALL hold its last value.
REQ-025 The last window pixel SHALL produce address IMG_W*IMG_H-1, and the next frame's first pixel SHALL return to 0 with no stale row_base.
REQ-026 frame_start SHALL assert for exactly one cycle, on the cycle vram_addr becomes 0 for the frame's first window pixel.
REQ-027 A window that extends past H_TOTAL or V_TOTAL SHALL be clipped, with no address wrap into the next line.

Reset
REQ-028 While reset is high: vram_addr=0, vr_pixel=0, in_window=0, frame_start=0, row_base=0, and the valid pipeline is cleared.
REQ-029 On reset release mid-frame, output SHALL be BG_PIXEL or correct image data; the first fully correct frame SHALL begin at the next forecast row YOFFSET.

Configuration
REQ-030 With macro VRAM_SCALE2X_EN defined, each image pixel SHALL cover 2x2 screen pixels: the window becomes 2*IMG_W by 2*IMG_H, the column index is (h-XOFFSET)>>1, and row_base advances on every second window row.
REQ-031 Without VRAM_SCALE2X_EN, mapping SHALL be 1:1 and the scaling logic SHALL be absent.

Structure
REQ-032 Package vram_pkg SHALL hold the 19-bit address width, the 30-bit pixel width and the default VGA timing constants (H_TOTAL, V_TOTAL).
REQ-033 One sub-module, vram_fetch_pipe, SHALL implement the parametrised RD_LAT-deep valid/pixel delay line.
REQ-034 Elaboration SHALL fail if IMG_W*IMG_H > 2^19 or RD_LAT is outside 1..4.

Verification
REQ-035 Defaults, ZBT model returning data=addr -> at sampled (h=5,v=3), vr_pixel[18:0]=1925 and in_window=1.
REQ-036 XOFFSET=100, YOFFSET=50, IMG_W=64, IMG_H=32 -> (h=99,v=50) gives BG_PIXEL; (h=100,v=50) gives addr 0; (h=163,v=81) gives addr 2047; (h=164,v=81) gives BG_PIXEL.
REQ-037 Sweep RD_LAT over 1..4 with the matching model latency -> zero pixel mismatches over two full frames.
REQ-038 Assert reset at (h=300,v=200) for 3 cycles -> all outputs are 0 during reset; the second frame after release is bit-exact.
REQ-039 VRAM_SCALE2X_EN, IMG_W=320, IMG_H=240 -> screen (h=3,v=5) reads addr 2*320+1=641; frame_start pulses exactly once per frame.
REQ-040 XOFFSET=1300, IMG_W=64 -> columns 1300..1343 display data; no window address appears in columns 0..43 of the next line.
